game_tick_gen: RTL

Lock-aware reset sequencer and gravity-tick generator clocked by the PLL-derived 1.171875 MHz game clock. It consumes the PLL `locked` indication and holds game logic in reset until lock has been stable for a settle interval. It then issues single-cycle gravity ticks whose period shrinks with the game level, with a faster soft-drop period. It sits between the game-clock PLL and the Tetris game state machine.

---
 rtl/game_tick_gen.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/game_tick_gen.sv
// -----------------------------------------------------------------------------
// game_tick_gen
//   Lock-aware reset sequencer and gravity-tick generator for the game clock.
//   Game logic is held in reset until the PLL lock has been stable for
//   SETTLE_CYCLES cycles; afterwards single-cycle gravity ticks are issued with
//   a period that shrinks with the game level (faster while soft drop is held).
//
// Ports
//   clk         game clock (PLL outclk_0)
//   rst_n       asynchronous active-low reset
//   locked      PLL lock indication, asynchronous to clk
//   level       current game level, 0..15
//   soft_drop   debounced soft-drop button
//   pause       freezes the tick counter while high
//   game_rst_n  reset to game logic, high only in RUN
//   tick        one-cycle gravity pulse
//   running     high while in RUN
//   lock_drops  saturating count of lock losses seen in RUN
// -----------------------------------------------------------------------------
module game_tick_gen #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned PERIOD_W      = 21,
  parameter int unsigned BASE_PERIOD   = 1171875,
  parameter int unsigned LEVEL_STEP    = 78125,
  parameter int unsigned MIN_PERIOD    = 58594,
  parameter int unsigned SOFT_PERIOD   = 58594
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       pause,
  output logic       game_rst_n,
  output logic       tick,
  output logic       running,
  output logic [7:0] lock_drops
);

  localparam int unsigned EXT_W    = PERIOD_W + 5;
  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_SETTLE    = 2'd1,
    S_RUN       = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_drop_event;

  logic                  r_lock_meta;
  logic                  r_lock_s;
  logic [SETTLE_W-1:0]   r_settle_cnt;
  logic [PERIOD_W-1:0]   r_period;
  logic [PERIOD_W-1:0]   r_cnt;
  logic                  r_tick;
  logic [7:0]            r_lock_drops;

  logic [EXT_W-1:0]      w_step_prod;
  logic [EXT_W-1:0]      w_eff_ext;
  logic [PERIOD_W-1:0]   w_eff;
  logic [PERIOD_W-1:0]   w_period_next;
  logic                  w_unused_hi;
  logic                  w_count_en;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; r_lock_s is the only consumer-facing lock signal.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT_LOCK;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_drop_event = 1'b0;
    case (r_state)
      S_WAIT_LOCK: begin
        if (r_lock_s) begin
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!r_lock_s) begin
          w_state_next = S_WAIT_LOCK;
        end else if (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!r_lock_s) begin
          w_state_next = S_WAIT_LOCK;
          w_drop_event = 1'b1;
        end
      end
      default: begin
        w_state_next = S_WAIT_LOCK;
      end
    endcase
  end

  // The settle counter sits at zero outside SETTLE, so entry always starts
  // a fresh count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
    end else if (r_state == S_SETTLE) begin
      r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
    end else begin
      r_settle_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_drops <= 8'd0;
    end else if (w_drop_event && (r_lock_drops != 8'hFF)) begin
      r_lock_drops <= r_lock_drops + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Period computation. The product is formed wide enough that the floor test
  // can never wrap, then the level period is clamped and soft drop applied.
  // ---------------------------------------------------------------------------
  assign w_step_prod = EXT_W'(level) * EXT_W'(LEVEL_STEP);
  assign w_eff_ext   = ((w_step_prod + EXT_W'(MIN_PERIOD)) > EXT_W'(BASE_PERIOD))
                       ? EXT_W'(MIN_PERIOD)
                       : (EXT_W'(BASE_PERIOD) - w_step_prod);
  assign w_eff       = w_eff_ext[PERIOD_W-1:0];
  // Upper bits are always zero because the result never exceeds BASE_PERIOD.
  assign w_unused_hi = ^w_eff_ext[EXT_W-1:PERIOD_W];

  assign w_period_next = (soft_drop && (w_eff > PERIOD_W'(SOFT_PERIOD)))
                         ? PERIOD_W'(SOFT_PERIOD)
                         : w_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= PERIOD_W'(BASE_PERIOD);
    end else begin
      r_period <= w_period_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick counter. Counting only happens while in RUN with lock still present,
  // so a lock loss clears the counter and suppresses any tick due that edge.
  // The >= compare lets a shortened period fire immediately.
  // ---------------------------------------------------------------------------
  assign w_count_en = (r_state == S_RUN) && r_lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!w_count_en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (pause) begin
      r_tick <= 1'b0;
    end else if (r_cnt >= (r_period - PERIOD_W'(1))) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + PERIOD_W'(1);
      r_tick <= 1'b0;
    end
  end

  // Decoded straight from the state flop so the async reset asserts them at once.
  assign game_rst_n = (r_state == S_RUN);
  assign running    = (r_state == S_RUN);
  assign tick       = r_tick;
  assign lock_drops = r_lock_drops;

endmodule
